// File: rtl/sobel_calc_pkg.sv
// Shared widths, latency and control-bundle type for the Sobel magnitude path.
package sobel_calc_pkg;
  localparam int PIX_W    = 8;
  localparam int SUM_W    = 10;
  localparam int MAG_W    = 11;
  localparam int PIPE_LAT = 3;
  localparam logic [PIX_W-1:0] THRESH_DEF = 8'd80;

  // Timing bits that ride alongside the pixel data through the pipeline.
  typedef struct packed {
    logic vsync;
    logic hsync;
    logic valid;
    logic border;
  } ctl_t;

  // Clamp an 11-bit magnitude into the 8-bit pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [MAG_W-1:0] m);
    return (m > MAG_W'(255)) ? {PIX_W{1'b1}} : m[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/sobel_calc_grad_axis.sv
// One gradient axis: weighted 1-2-1 sums on each side (stage 1), then the
// registered absolute difference of the two sums (stage 2).
module sobel_grad_axis
  import sobel_calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] p0,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] n0,
  input  logic [PIX_W-1:0] n1,
  input  logic [PIX_W-1:0] n2,
  output logic [SUM_W-1:0] abs_diff
);
  logic [SUM_W-1:0] sum_p, sum_n;

  // Stage 1: zero-extended weighted sums, centre tap doubled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p <= '0;
      sum_n <= '0;
    end else begin
      sum_p <= {2'b00, p0} + {1'b0, p1, 1'b0} + {2'b00, p2};
      sum_n <= {2'b00, n0} + {1'b0, n1, 1'b0} + {2'b00, n2};
    end
  end

  // Stage 2: unsigned absolute difference, at most 1020.
  always_ff @(posedge clk) begin
    if (rst) abs_diff <= '0;
    else     abs_diff <= (sum_p >= sum_n) ? (sum_p - sum_n) : (sum_n - sum_p);
  end
endmodule

// File: rtl/sobel_calc.sv
// Sobel edge magnitude, binarisation and per-frame edge-pixel counting.
// Three-cycle pipeline; threshold swaps only at a vsync rising edge.
module sobel_calc
  import sobel_calc_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH_DEFAULT = THRESH_DEF,
  parameter int               CNT_W          = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             matrix_img_vsync,
  input  logic             matrix_img_hsync,
  input  logic             matrix_img_valid,
  input  logic             matrix_top_edge_flag,
  input  logic             matrix_bottom_edge_flag,
  input  logic             matrix_left_edge_flag,
  input  logic             matrix_right_edge_flag,
  input  logic [PIX_W-1:0] matrix_p11,
  input  logic [PIX_W-1:0] matrix_p12,
  input  logic [PIX_W-1:0] matrix_p13,
  input  logic [PIX_W-1:0] matrix_p21,
  input  logic [PIX_W-1:0] matrix_p22,
  input  logic [PIX_W-1:0] matrix_p23,
  input  logic [PIX_W-1:0] matrix_p31,
  input  logic [PIX_W-1:0] matrix_p32,
  input  logic [PIX_W-1:0] matrix_p33,
  input  logic [PIX_W-1:0] threshold_in,
  output logic             post_img_vsync,
  output logic             post_img_hsync,
  output logic             post_img_valid,
  output logic [PIX_W-1:0] post_img_mag,
  output logic [PIX_W-1:0] post_img_bin,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             edge_cnt_vld
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctl_t                    ctl_in;
  ctl_t [PIPE_LAT-1:0]     ctl_pipe;
  logic [SUM_W-1:0]        gx_abs, gy_abs;
  logic [MAG_W-1:0]        mag;
  logic                    pix_ok, is_edge;
  logic [PIX_W-1:0]        thresh;
  logic                    vsync_d, frame_start, counted;
  logic [CNT_W-1:0]        run_cnt;

  // The centre pixel carries no weight in either kernel.
  logic unused_p22;
  assign unused_p22 = ^matrix_p22;

  assign ctl_in = {matrix_img_vsync, matrix_img_hsync, matrix_img_valid,
                   matrix_top_edge_flag | matrix_bottom_edge_flag |
                   matrix_left_edge_flag | matrix_right_edge_flag};

  // Gx: right column minus left column.
  sobel_grad_axis u_gx (
    .clk(clk), .rst(rst),
    .p0(matrix_p13), .p1(matrix_p23), .p2(matrix_p33),
    .n0(matrix_p11), .n1(matrix_p21), .n2(matrix_p31),
    .abs_diff(gx_abs)
  );

  // Gy: bottom row minus top row.
  sobel_grad_axis u_gy (
    .clk(clk), .rst(rst),
    .p0(matrix_p31), .p1(matrix_p32), .p2(matrix_p33),
    .n0(matrix_p11), .n1(matrix_p12), .n2(matrix_p13),
    .abs_diff(gy_abs)
  );

  // Stage 3 inputs: magnitude and qualification from the stage-2 control slot.
  always_comb begin
    mag     = {1'b0, gx_abs} + {1'b0, gy_abs};
    pix_ok  = ctl_pipe[PIPE_LAT-2].valid & ~ctl_pipe[PIPE_LAT-2].border;
    is_edge = mag > {{(MAG_W-PIX_W){1'b0}}, thresh};
  end

  // Control shift register and stage-3 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_pipe     <= '0;
      post_img_mag <= '0;
      post_img_bin <= '0;
    end else begin
      ctl_pipe     <= {ctl_pipe[PIPE_LAT-2:0], ctl_in};
      post_img_mag <= pix_ok ? sat_pix(mag) : '0;
      post_img_bin <= (pix_ok && is_edge) ? {PIX_W{1'b1}} : '0;
    end
  end

  assign post_img_vsync = ctl_pipe[PIPE_LAT-1].vsync;
  assign post_img_hsync = ctl_pipe[PIPE_LAT-1].hsync;
  assign post_img_valid = ctl_pipe[PIPE_LAT-1].valid;

  assign frame_start = matrix_img_vsync & ~vsync_d;
  assign counted     = post_img_valid & (post_img_bin == {PIX_W{1'b1}});

  // Frame bookkeeping: latch threshold, publish last count, restart counter.
  // A pixel counted in the frame-start cycle belongs to the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      thresh       <= THRESH_DEFAULT;
      run_cnt      <= '0;
      edge_cnt     <= '0;
      edge_cnt_vld <= 1'b0;
    end else begin
      vsync_d      <= matrix_img_vsync;
      edge_cnt_vld <= frame_start;
      if (frame_start) begin
        thresh   <= threshold_in;
        edge_cnt <= run_cnt;
        run_cnt  <= counted ? CNT_W'(1) : '0;
      end else if (counted && run_cnt != CNT_MAX) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sobel_calc.sv
// Self-checking bench for sobel_calc: directed scenarios plus random frames,
// compared every cycle against a behavioural model of the Sobel rules.
module tb_sobel_calc;
  logic       clk = 1'b0;
  logic       rst;
  logic       vs, hs, vl, ft, fb, fl, fr;
  logic [7:0] pix [9];
  logic [7:0] thr_in;
  logic       o_vs, o_hs, o_vl, o_cv;
  logic [7:0] o_mag, o_bin;
  logic [19:0] o_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sobel_calc #(.THRESH_DEFAULT(8'd80), .CNT_W(20)) dut (
    .clk(clk), .rst(rst),
    .matrix_img_vsync(vs), .matrix_img_hsync(hs), .matrix_img_valid(vl),
    .matrix_top_edge_flag(ft), .matrix_bottom_edge_flag(fb),
    .matrix_left_edge_flag(fl), .matrix_right_edge_flag(fr),
    .matrix_p11(pix[0]), .matrix_p12(pix[1]), .matrix_p13(pix[2]),
    .matrix_p21(pix[3]), .matrix_p22(pix[4]), .matrix_p23(pix[5]),
    .matrix_p31(pix[6]), .matrix_p32(pix[7]), .matrix_p33(pix[8]),
    .threshold_in(thr_in),
    .post_img_vsync(o_vs), .post_img_hsync(o_hs), .post_img_valid(o_vl),
    .post_img_mag(o_mag), .post_img_bin(o_bin),
    .edge_cnt(o_cnt), .edge_cnt_vld(o_cv)
  );

  // Behavioural model state: windows in flight, frame threshold, counters.
  typedef struct {
    bit vs, hs, vl, border;
    int p [9];
  } win_t;

  win_t s1, s2;
  int   m_thr, m_cnt, e_mag, e_bin, e_cnt;
  bit   m_pvs, e_vs, e_hs, e_vl, e_cv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Sobel magnitude straight from the kernel definition.
  function automatic int sobel_mag(input win_t w);
    int gx, gy;
    gx = (w.p[2] + 2*w.p[5] + w.p[8]) - (w.p[0] + 2*w.p[3] + w.p[6]);
    gy = (w.p[6] + 2*w.p[7] + w.p[8]) - (w.p[0] + 2*w.p[1] + w.p[2]);
    return iabs(gx) + iabs(gy);
  endfunction

  function automatic win_t blank_win();
    win_t w;
    w.vs = 0; w.hs = 0; w.vl = 0; w.border = 0;
    foreach (w.p[i]) w.p[i] = 0;
    return w;
  endfunction

  // Advance one clock: update the model for this edge, then compare all outputs.
  task automatic step();
    win_t cur;
    bit   prev_counted, fs;
    int   m;
    cur.vs = vs; cur.hs = hs; cur.vl = vl; cur.border = ft | fb | fl | fr;
    foreach (cur.p[i]) cur.p[i] = int'(pix[i]);
    if (rst) begin
      s1 = blank_win(); s2 = blank_win();
      m_thr = 80; m_cnt = 0; m_pvs = 0;
      e_vs = 0; e_hs = 0; e_vl = 0; e_mag = 0; e_bin = 0; e_cnt = 0; e_cv = 0;
    end else begin
      prev_counted = e_vl && (e_bin == 255);
      fs = cur.vs && !m_pvs;
      e_vs = s2.vs; e_hs = s2.hs; e_vl = s2.vl;
      m = sobel_mag(s2);
      if (s2.vl && !s2.border) begin
        e_mag = (m > 255) ? 255 : m;
        e_bin = (m > m_thr) ? 255 : 0;
      end else begin
        e_mag = 0; e_bin = 0;
      end
      e_cv = fs;
      if (fs) begin
        e_cnt = m_cnt;
        m_cnt = prev_counted ? 1 : 0;
        m_thr = int'(thr_in);
      end else if (prev_counted && m_cnt < (1 << 20) - 1) begin
        m_cnt++;
      end
      m_pvs = cur.vs;
      s2 = s1; s1 = cur;
    end
    @(posedge clk);
    #1;
    chk("vsync", o_vs, e_vs);
    chk("hsync", o_hs, e_hs);
    chk("valid", o_vl, e_vl);
    chk("mag",   o_mag, e_mag);
    chk("bin",   o_bin, e_bin);
    chk("cnt",   o_cnt, e_cnt);
    chk("cnt_vld", o_cv, e_cv);
  endtask

  task automatic idle();
    vs = 0; hs = 0; vl = 0; ft = 0; fb = 0; fl = 0; fr = 0;
    foreach (pix[i]) pix[i] = 8'd0;
  endtask

  task automatic fill(input int v);
    foreach (pix[i]) pix[i] = 8'(v);
  endtask

  // Left column 0, right column 255: |Gx|=1020, |Gy|=0.
  task automatic vert_edge();
    fill(128);
    pix[0] = 0;   pix[3] = 0;   pix[6] = 0;
    pix[2] = 255; pix[5] = 255; pix[8] = 255;
  endtask

  // Only p23 set: magnitude is exactly 2*v.
  task automatic mid_right(input int v);
    fill(0);
    pix[5] = 8'(v);
  endtask

  task automatic frame_pulse();
    idle(); vs = 1; step(); step(); vs = 0;
  endtask

  task automatic flush();
    idle(); repeat (4) step();
  endtask

  initial begin
    idle();
    thr_in = 8'd80;
    rst = 1;
    step(); step();
    chk("rst_mag", o_mag, 0);
    chk("rst_cnt", o_cnt, 0);
    rst = 0;
    frame_pulse();

    // Uniform window: zero gradient.
    fill(100); vl = 1; step();
    idle(); step(); step();
    chk("uniform_valid", o_vl, 1);
    chk("uniform_mag", o_mag, 0);
    chk("uniform_bin", o_bin, 0);

    // Strong vertical edge saturates the magnitude.
    vert_edge(); vl = 1; step();
    idle(); step(); step();
    chk("vedge_mag", o_mag, 255);
    chk("vedge_bin", o_bin, 255);

    // Threshold boundary: Sobel magnitudes are always even, so 80 vs 82.
    mid_right(40); vl = 1; step();
    mid_right(41); vl = 1; step();
    idle(); step();
    chk("mag80_mag", o_mag, 80);
    chk("mag80_bin", o_bin, 0);
    step();
    chk("mag82_mag", o_mag, 82);
    chk("mag82_bin", o_bin, 255);

    // Border flag suppresses output and counting.
    vert_edge(); vl = 1; fl = 1; step();
    idle(); step(); step();
    chk("border_mag", o_mag, 0);
    chk("border_bin", o_bin, 0);
    flush();

    // Frame of 10 edges with a mid-frame threshold request of 200.
    frame_pulse();
    for (int i = 0; i < 9; i++) begin
      vert_edge(); vl = 1; hs = (i % 3 == 0); step();
      idle(); step();
      if (i == 4) thr_in = 8'd200;
    end
    mid_right(75); vl = 1; step();
    idle(); step(); step();
    chk("oldthr_bin", o_bin, 255);
    flush();
    vs = 1; step();
    chk("frame_cnt", o_cnt, 10);
    chk("frame_vld", o_cv, 1);
    step();
    chk("frame_vld_pulse", o_cv, 0);
    vs = 0;
    mid_right(75); vl = 1; step();
    idle(); step(); step();
    chk("newthr_bin", o_bin, 0);

    // Random frames: random windows, flags, syncs and threshold requests.
    for (int f = 0; f < 6; f++) begin
      thr_in = 8'($urandom_range(0, 255));
      frame_pulse();
      for (int c = 0; c < 60; c++) begin
        vl = ($urandom_range(0, 3) != 0);
        hs = ($urandom_range(0, 7) == 0);
        ft = ($urandom_range(0, 15) == 0);
        fr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 1) == 1) foreach (pix[i]) pix[i] = 8'($urandom);
        else foreach (pix[i]) pix[i] = 8'($urandom_range(0, 40));
        if (c == 30) thr_in = 8'($urandom_range(0, 255));
        step();
      end
      idle(); step();
    end
    // A frame start that lands on a counted pixel.
    vert_edge(); vl = 1; step();
    idle(); step();
    vs = 1; step();
    vs = 0; step();

    // Reset mid-frame with pixels in flight.
    thr_in = 8'd200;
    frame_pulse();
    vert_edge(); vl = 1; step(); step();
    rst = 1; step();
    chk("midrst_valid", o_vl, 0);
    chk("midrst_mag", o_mag, 0);
    chk("midrst_vld", o_cv, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      mid_right(75); vl = 1; step();
    end
    idle(); step(); step();
    chk("postrst_thr_bin", o_bin, 255);
    flush();
    vs = 1; step();
    chk("postrst_cnt", o_cnt, 3);
    chk("postrst_vld", o_cv, 1);
    vs = 0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
